// File: rtl/spi_record_ctrl.sv
//-----------------------------------------------------------------------------
// spi_record_ctrl
//
// Sysclock-side controller for the 256-byte SPI peripheral record.
//
// The FPGA->Arduino (cipo) record is a 2048-bit register that is shared
// between NUM_REQ user-logic writers. A round-robin arbiter grants at most one
// 32-bit word write per cycle, and grants only while no SPI transfer is in
// progress. Once a transfer has finished, the Arduino->FPGA (copi) record is
// snapshotted into rx_data and rx_valid pulses for one cycle.
//
// Ports
//   sysclock       in   1            system clock, rising edge
//   sysreset_n     in   1            asynchronous active-low reset
//   spi_busy       in   1            SPI driver busy (SPI clock domain)
//   spi_copi_data  in   2048         copi record from the SPI driver
//   spi_cipo_data  out  2048         registered cipo record to the SPI driver
//   req            in   NUM_REQ      per-writer write request
//   req_addr       in   NUM_REQ*6    per-writer word index 0..63
//   req_wdata      in   NUM_REQ*32   per-writer write data
//   gnt            out  NUM_REQ      one-hot grant (combinational)
//   rx_data        out  2048         copi snapshot of the last transfer
//   rx_valid       out  1            one-cycle pulse when rx_data updates
//   xfer_cnt       out  16           completed-transfer counter (wrapping)
//   locked         out  1            high while writes are blocked
//-----------------------------------------------------------------------------
module spi_record_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sysclock,
  input  logic                    sysreset_n,
  input  logic                    spi_busy,
  input  logic [2047:0]           spi_copi_data,
  output logic [2047:0]           spi_cipo_data,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*6-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [2047:0]           rx_data,
  output logic                    rx_valid,
  output logic [15:0]             xfer_cnt,
  output logic                    locked
);

  // A pointer needs at least one bit even when there is a single writer.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [SYNC_STAGES-1:0] r_busySync;
  logic [1:0]             r_state;
  logic [1:0]             w_stateNext;
  logic [PTR_W-1:0]       r_ptr;
  logic [2047:0]          r_cipoData;
  logic [2047:0]          r_rxData;
  logic                   r_rxValid;
  logic [15:0]            r_xferCnt;

  logic                   w_busyS;
  logic                   w_gntValid;
  logic [PTR_W-1:0]       w_gntIdx;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [5:0]             w_selAddr;
  logic [31:0]            w_selData;

  // Plain flop chain bringing spi_busy into the sysclock domain; only the last
  // stage is used by control logic.
  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_busySync <= '0;
    end else begin
      r_busySync <= {r_busySync[SYNC_STAGES-2:0], spi_busy};
    end
  end

  assign w_busyS = r_busySync[SYNC_STAGES-1];

  // Transfer tracking: IDLE until busy is seen, LOCKED for the transfer, then
  // a single CAPTURE cycle in which the copi record is known to be stable.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (w_busyS)  w_stateNext = ST_LOCKED;
      ST_LOCKED:  if (!w_busyS) w_stateNext = ST_CAPTURE;
      ST_CAPTURE: w_stateNext = ST_IDLE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Round-robin search in two passes: first the requesters at or above the
  // pointer, then the ones below it, which gives the upward search with wrap.
  // Nothing is granted outside IDLE so the record stays frozen mid-transfer.
  always_comb begin
    w_gntValid = 1'b0;
    w_gntIdx   = '0;
    w_gnt      = '0;
    w_selAddr  = '0;
    w_selData  = '0;
    if (r_state == ST_IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_gntValid && req[i] && (PTR_W'(i) >= r_ptr)) begin
          w_gntValid = 1'b1;
          w_gntIdx   = PTR_W'(i);
          w_gnt[i]   = 1'b1;
          w_selAddr  = req_addr[6*i +: 6];
          w_selData  = req_wdata[32*i +: 32];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_gntValid && req[i] && (PTR_W'(i) < r_ptr)) begin
          w_gntValid = 1'b1;
          w_gntIdx   = PTR_W'(i);
          w_gnt[i]   = 1'b1;
          w_selAddr  = req_addr[6*i +: 6];
          w_selData  = req_wdata[32*i +: 32];
        end
      end
    end
  end

  assign gnt = w_gnt;

  // The granted word lands on the edge that closes the grant cycle, and the
  // pointer moves just past the winner so every writer gets a fair turn.
  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_ptr      <= '0;
      r_cipoData <= '0;
    end else if (w_gntValid) begin
      r_ptr                              <= (w_gntIdx == LAST_IDX) ? '0 : w_gntIdx + 1'b1;
      r_cipoData[{w_selAddr, 5'd0} +: 32] <= w_selData;
    end
  end

  // The copi snapshot is taken on the edge leaving CAPTURE; rx_valid is high
  // for exactly the cycle that follows it.
  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_xferCnt <= '0;
    end else begin
      r_rxValid <= (r_state == ST_CAPTURE);
      if (r_state == ST_CAPTURE) begin
        r_rxData  <= spi_copi_data;
        r_xferCnt <= r_xferCnt + 16'd1;
      end
    end
  end

  assign spi_cipo_data = r_cipoData;
  assign rx_data       = r_rxData;
  assign rx_valid      = r_rxValid;
  assign xfer_cnt      = r_xferCnt;
  assign locked        = (r_state != ST_IDLE);

endmodule
